pipe_skid_latch: RTL and testbench
==================================

Name: pipe_skid_latch

Overview:
- Parametrised pipeline-stage latch that replaces the per-stage hand-written latches (fetch/decode/execute/memory).
- Carries an opaque WIDTH-bit payload bundle with a valid/ready handshake.
- Contains a 2-entry skid buffer, so the downstream stall is registered and never a combinational path upstream.
- Synchronous flush inserts bubbles. Sits between any two pipeline stages of the CPU datapath.

Parameters:
- WIDTH, 128, payload bundle width in bits (control plus data fields packed by the stage).
- NOP_VALUE, '0, payload value driven/stored whenever the latch holds a bubble.
- CNT_W, 32, width of the optional performance counters.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- nRST  input  1  synchronous active-low reset, sampled on rising CLK.
- flush  input  1  synchronous flush; discards all held entries.
- in_valid  input  1  upstream has a payload.
- in_ready  output  1  latch can accept; derived from registered state only.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data is a real instruction.
- out_ready  input  1  downstream accepts this cycle (stall = !out_ready).
- out_data  output  WIDTH  head payload; NOP_VALUE when empty.
- occupancy  output  2  entries held: 0, 1 or 2.
- stall_cnt, bubble_cnt, flush_cnt  output  CNT_W each  present only with PIPE_LATCH_PERF_EN.

Behaviour:
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Registers: state (EMPTY/ONE/FULL), main_q, skid_q. out_data = main_q; out_valid = (state != EMPTY); in_ready = nRST & (state != FULL); occupancy = state encoding.
- Reset (nRST low at edge): state = EMPTY, main_q = skid_q = NOP_VALUE. Hence out_valid = 0, out_data = NOP_VALUE, occupancy = 0. in_ready is 0 while nRST is low and 1 in the first cycle after release. Reset dominates flush and any handshake.
- Flush (nRST high, flush high): state = EMPTY, main_q = skid_q = NOP_VALUE. An in_fire in the same cycle is dropped; an out_fire in the same cycle is still consumed downstream.
- EMPTY:
  - in_fire: main_q = in_data, go to ONE.
  - Otherwise hold.
- ONE:
  - in_fire & out_fire: main_q = in_data, stay ONE.
  - in_fire only: skid_q = in_data, go to FULL.
  - out_fire only: main_q = NOP_VALUE, go to EMPTY.
  - Neither: hold.
- FULL (in_ready = 0):
  - out_fire: main_q = skid_q, skid_q = NOP_VALUE, go to ONE.
  - Otherwise hold.
- Latency and throughput: 1 cycle in_fire to out_valid; sustained 1 payload/cycle when out_ready stays high.
- Ordering: strict FIFO; no payload is ever lost or duplicated except by flush.
- Data rules: payload is never modified or inspected. Held data is stable while out_valid & !out_ready.
- Illegal state encoding 2'b11 recovers to EMPTY on the next edge.

Optional Feature:
- Macro: PIPE_LATCH_PERF_EN.
- Defined:
  - stall_cnt increments each cycle out_valid & !out_ready.
  - bubble_cnt increments each cycle out_ready & !out_valid.
  - flush_cnt increments each flush cycle.
  - All counters saturate at 2^CNT_W-1, clear only on reset, and are not cleared by flush.
- Undefined: counter ports and logic are absent; core behaviour is identical.

Decomposition:
- Package pipe_latch_pkg: typedef enum logic [1:0] latch_state_t {EMPTY=2'd0, ONE=2'd1, FULL=2'd2}; localparam OCC_W = 2.
- Interface pipe_skid_latch_if: modports fl and tb, mirroring the existing latch interfaces.
- Stages pack/unpack their fields (word_t, regbits_t, aluop_t from cpu_types_pkg) into WIDTH in the stage wrapper.
- One sub-module: pipe_sat_counter (CNT_W, inc, saturating), instantiated 3x under the macro.

Test Plan:
- Reset then stream: nRST low 2 cycles, then in_valid=1 with data 1,2,3,4 and out_ready=1. Expect out_data 1,2,3,4 one cycle later each, occupancy 1, in_ready 1 throughout.
- Stall/skid: in ONE holding 0xA, drive 0xB with out_ready=0 → FULL, in_ready=0, out_data=0xA held. Raise out_ready → 0xA then 0xB out, occupancy 2→1→0.
- Flush in FULL with in_valid=1 (0xC) → next cycle EMPTY, out_valid=0, out_data=NOP_VALUE, 0xC never appears.
- Reset mid-operation: FULL with nRST low and flush=1 → EMPTY, in_ready=0 during reset, in_ready=1 the cycle after release.
- Simultaneous in/out in ONE for 10 cycles with incrementing data → occupancy stays 1, no loss, no duplication.
- PIPE_LATCH_PERF_EN with CNT_W=4: 20 stall cycles → stall_cnt=15 (saturated). Flush does not clear it; reset clears it to 0.

Source files
------------

// File: rtl/pipe_latch_pkg.sv
// Shared types for the pipeline skid latch: latch state encoding and
// occupancy width. The state encoding doubles as the occupancy count.
package pipe_latch_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } latch_state_t;

  localparam int OCC_W = 2;

endpackage

// File: rtl/pipe_skid_latch_if.sv
// Bundle interface for a pipe_skid_latch. The fl modport is the latch's
// view; tb is the driver/observer view. Counter signals exist only when
// PIPE_LATCH_PERF_EN is defined.
interface pipe_skid_latch_if
  import pipe_latch_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int CNT_W = 32
) (
  input logic CLK
);
  logic             nRST;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [OCC_W-1:0] occupancy;
`ifdef PIPE_LATCH_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;
  logic [CNT_W-1:0] flush_cnt;
`endif

  modport fl (
    input  CLK, nRST, flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
`ifdef PIPE_LATCH_PERF_EN
    , output stall_cnt, bubble_cnt, flush_cnt
`endif
  );

  modport tb (
    input  CLK, in_ready, out_valid, out_data, occupancy,
    output nRST, flush, in_valid, in_data, out_ready
`ifdef PIPE_LATCH_PERF_EN
    , input stall_cnt, bubble_cnt, flush_cnt
`endif
  );

endinterface

// File: rtl/pipe_sat_counter.sv
// Saturating event counter: counts up on inc, sticks at all-ones,
// clears only on synchronous reset.
module pipe_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  // Count register with synchronous clear.
  always_ff @(posedge CLK) begin
    if (!nRST) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_skid_latch.sv
// Pipeline-stage latch with a 2-entry skid buffer. in_ready depends only
// on registered state (and reset), so downstream stall never reaches
// upstream combinationally. Payload is opaque; bubbles read NOP_VALUE.
// Optional performance counters are built when PIPE_LATCH_PERF_EN is
// defined.
module pipe_skid_latch
  import pipe_latch_pkg::*;
#(
  parameter int               WIDTH     = 128,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter int               CNT_W     = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
`ifdef PIPE_LATCH_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  // Elaboration-time sanity on widths.
  if (WIDTH < 1) begin : g_bad_width
    $error("pipe_skid_latch: WIDTH must be >= 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("pipe_skid_latch: CNT_W must be >= 1");
  end

  latch_state_t     state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire, out_fire;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = nRST & (state_q != FULL);
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Next-state: head stays in main_q, the second entry parks in skid_q.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Incoming beat is dropped; an out_fire this cycle was already taken.
      state_d = EMPTY;
      main_d  = NOP_VALUE;
      skid_d  = NOP_VALUE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (out_fire) begin
            main_d  = NOP_VALUE;
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            skid_d  = NOP_VALUE;
            state_d = ONE;
          end
        end
        default: begin
          // Unreachable encoding: drop whatever is held and restart empty.
          state_d = EMPTY;
          main_d  = NOP_VALUE;
          skid_d  = NOP_VALUE;
        end
      endcase
    end
  end

  // State and payload registers; reset dominates flush and handshakes.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= EMPTY;
      main_q  <= NOP_VALUE;
      skid_q  <= NOP_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_LATCH_PERF_EN
  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (out_valid & ~out_ready),
    .cnt  (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (out_ready & ~out_valid),
    .cnt  (bubble_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (flush),
    .cnt  (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_skid_latch.sv
// Bench for pipe_skid_latch: a table of per-cycle vectors with expected
// outputs, plus a FIFO scoreboard that records accepted payloads and
// compares them as they leave. Counter checks run when
// PIPE_LATCH_PERF_EN is defined.
module tb_pipe_skid_latch;
  import pipe_latch_pkg::*;

  localparam int               W     = 32;
  localparam logic [W-1:0]     NOP   = '0;
  localparam int               CNT_W = 4;

  logic             CLK = 1'b0;
  logic             nRST, flush, in_valid, out_ready;
  logic [W-1:0]     in_data;
  logic             in_ready, out_valid;
  logic [W-1:0]     out_data;
  logic [OCC_W-1:0] occupancy;
`ifdef PIPE_LATCH_PERF_EN
  logic [CNT_W-1:0] stall_cnt, bubble_cnt, flush_cnt;
`endif

  always #5 CLK = ~CLK;

  pipe_skid_latch #(.WIDTH(W), .NOP_VALUE(NOP), .CNT_W(CNT_W)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPE_LATCH_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  typedef struct {
    bit           nrst;
    bit           fl;
    bit           iv;
    logic [W-1:0] d;
    bit           ordy;
    bit           ev;
    logic [W-1:0] ed;
    logic [1:0]   eocc;
    bit           erdy;
  } vec_t;

  vec_t         tbl[$];
  logic [W-1:0] sb[$];
  int           total = 0;
  int           bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void add(input bit nrst, input bit fl, input bit iv,
                              input logic [W-1:0] d, input bit ordy, input bit ev,
                              input logic [W-1:0] ed, input logic [1:0] eocc,
                              input bit erdy);
    vec_t v;
    v.nrst = nrst; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.ev = ev; v.ed = ed; v.eocc = eocc; v.erdy = erdy;
    tbl.push_back(v);
  endfunction

  // One clock: drive, sample handshakes before the edge, then run the
  // scoreboard against what left and what entered.
  task automatic cycle(input bit nrst, input bit fl, input bit iv,
                       input logic [W-1:0] d, input bit ordy);
    bit           inf, outf;
    logic [W-1:0] od, exp_d;
    nRST = nrst; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    inf  = (iv && in_ready === 1'b1);
    outf = (out_valid === 1'b1 && ordy);
    od   = out_data;
    @(posedge CLK);
    #1;
    if (outf) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_d = sb.pop_front();
        chk("sb_data", 64'(od), 64'(exp_d));
      end
    end
    if (!nrst || fl) sb.delete();
    else if (inf)    sb.push_back(d);
  endtask

  initial begin
    nRST = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // reset, 2 cycles
    add(0,0,0,0,0,  0,NOP,0,0);
    add(0,0,0,0,0,  0,NOP,0,0);
    // stream 1..4 with out_ready high, then drain
    add(1,0,1,1,1,  1,1,1,1);
    add(1,0,1,2,1,  1,2,1,1);
    add(1,0,1,3,1,  1,3,1,1);
    add(1,0,1,4,1,  1,4,1,1);
    add(1,0,0,0,1,  0,NOP,0,1);
    // stall into skid, hold, then drain A then B
    add(1,0,1,32'hA,0,  1,32'hA,1,1);
    add(1,0,1,32'hB,0,  1,32'hA,2,0);
    add(1,0,0,0,0,      1,32'hA,2,0);
    add(1,0,0,0,1,      1,32'hB,1,1);
    add(1,0,0,0,1,      0,NOP,0,1);
    // flush while FULL with a concurrent input; C must never appear
    add(1,0,1,32'hA,0,  1,32'hA,1,1);
    add(1,0,1,32'hB,0,  1,32'hA,2,0);
    add(1,1,1,32'hC,0,  0,NOP,0,1);
    add(1,0,0,0,1,      0,NOP,0,1);
    // reset mid-operation with flush and handshakes asserted
    add(1,0,1,32'hA,0,  1,32'hA,1,1);
    add(1,0,1,32'hB,0,  1,32'hA,2,0);
    add(0,1,1,32'h55,1, 0,NOP,0,0);
    add(1,0,0,0,0,      0,NOP,0,1);
    // simultaneous in/out in ONE for 10 cycles
    add(1,0,1,32'h100,1, 1,32'h100,1,1);
    for (int i = 1; i <= 10; i++)
      add(1,0,1,32'h100+i,1, 1,32'h100+i,1,1);
    add(1,0,0,0,1,      0,NOP,0,1);

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].nrst, tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'(tbl[i].ev));
      chk($sformatf("v%0d_data",  i), 64'(out_data),  64'(tbl[i].ed));
      chk($sformatf("v%0d_occ",   i), 64'(occupancy), 64'(tbl[i].eocc));
      chk($sformatf("v%0d_ready", i), 64'(in_ready),  64'(tbl[i].erdy));
    end
    chk("sb_drained", 64'(sb.size()), 64'd0);

`ifdef PIPE_LATCH_PERF_EN
    cycle(0,0,0,0,0);
    cycle(0,0,0,0,0);
    chk("perf_rst_stall",  64'(stall_cnt),  64'd0);
    chk("perf_rst_bubble", 64'(bubble_cnt), 64'd0);
    chk("perf_rst_flush",  64'(flush_cnt),  64'd0);
    cycle(1,0,1,32'h77,0);
    for (int i = 0; i < 20; i++) cycle(1,0,0,0,0);
    chk("perf_stall_sat", 64'(stall_cnt), 64'd15);
    cycle(1,1,0,0,0);
    chk("perf_stall_after_flush", 64'(stall_cnt), 64'd15);
    chk("perf_flush_cnt",         64'(flush_cnt), 64'd1);
    cycle(1,0,0,0,1);
    chk("perf_bubble", 64'(bubble_cnt), 64'd1);
    cycle(0,0,0,0,0);
    chk("perf_clr_stall",  64'(stall_cnt),  64'd0);
    chk("perf_clr_bubble", 64'(bubble_cnt), 64'd0);
    chk("perf_clr_flush",  64'(flush_cnt),  64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
